// File: rtl/press_pkg.sv
// Shared definitions for the button press classifier: FSM encoding,
// timer limits and default timing parameters.
package press_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        HOLD   = 3'd2,
        WAIT2  = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    // 2^19 cycles is roughly 10 ms at 50 MHz
    localparam int TICK_BITS_DEF  = 19;
    localparam int LONG_TICKS_DEF = 50;
    localparam int DBL_TICKS_DEF  = 25;

    localparam int         TCNT_W   = 7;
    localparam logic [6:0] TCNT_MAX = 7'd127;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for the single cycle in which the
// counter sits at all-ones, after which it wraps to zero.
module tick_gen
    import press_pkg::*;
#(
    parameter int TICK_BITS = TICK_BITS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    logic [TICK_BITS-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/press_classifier.sv
// Classifies a debounced button into short, long and double presses,
// emitting one-cycle registered pulses and a running event count.
module press_classifier
    import press_pkg::*;
#(
    parameter int TICK_BITS  = TICK_BITS_DEF,
    parameter int LONG_TICKS = LONG_TICKS_DEF,
    parameter int DBL_TICKS  = DBL_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       db,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       busy,
    output logic [7:0] press_count
);

    localparam logic [TCNT_W-1:0] LONG_LAST = TCNT_W'(LONG_TICKS - 1);
    localparam logic [TCNT_W-1:0] DBL_LAST  = TCNT_W'(DBL_TICKS - 1);

    logic              tick;
    logic              db_q;
    logic              rise, fall;
    state_t            state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              dbl_q, dbl_d;
    logic              busy_q, busy_d;
    logic [7:0]        count_q, count_d;

    tick_gen #(
        .TICK_BITS(TICK_BITS)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q    <= 1'b0;
            state_q <= IDLE;
            tcnt_q  <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            db_q    <= db;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Edges are tested before timeouts so a coincident edge always wins.
    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_d = WAIT2;
                end else if (tick && tcnt_q == LONG_LAST) begin
                    state_d = HOLD;
                    long_d  = 1'b1;
                end
            end
            HOLD: begin
                if (fall) state_d = IDLE;
            end
            WAIT2: begin
                if (rise) begin
                    state_d = PRESS2;
                end else if (tick && tcnt_q == DBL_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The timer restarts on every state change and sticks at its maximum.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (tick && tcnt_q != TCNT_MAX) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_comb begin
        busy_d  = (state_d != IDLE);
        count_d = count_q;
        if (short_d || long_d || dbl_d) begin
            count_d = count_q + 8'd1;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = dbl_q;
    assign busy         = busy_q;
    assign press_count  = count_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with a 4-cycle tick, LONG_TICKS=5 and
// DBL_TICKS=3; edges are numbered from the last posedge with reset low.
module tb_press_classifier;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       db = 1'b0;
    logic       short_press, long_press, double_press, busy;
    logic [7:0] press_count;

    int nAsserts = 0;
    int nFails   = 0;

    int firstS, firstL, firstD;
    int cntS, cntL, cntD;

    always #5 clk = ~clk;

    press_classifier #(
        .TICK_BITS (2),
        .LONG_TICKS(5),
        .DBL_TICKS (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .db          (db),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .busy        (busy),
        .press_count (press_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after edge E0 with reset released.
    task automatic do_reset();
        reset_n = 1'b0;
        db      = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic clear_obs();
        firstS = -1; firstL = -1; firstD = -1;
        cntS = 0; cntL = 0; cntD = 0;
    endtask

    task automatic observe(input int e);
        if (short_press) begin
            cntS++;
            if (firstS < 0) firstS = e;
        end
        if (long_press) begin
            cntL++;
            if (firstL < 0) firstL = e;
        end
        if (double_press) begin
            cntD++;
            if (firstD < 0) firstD = e;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        db      = 1'b1;
        step(); step(); step();
        nAsserts++;
        if (short_press !== 1'b0) begin nFails++; $display("[TB] FAIL reset.short: got %b expected 0", short_press); end
        nAsserts++;
        if (long_press !== 1'b0) begin nFails++; $display("[TB] FAIL reset.long: got %b expected 0", long_press); end
        nAsserts++;
        if (double_press !== 1'b0) begin nFails++; $display("[TB] FAIL reset.double: got %b expected 0", double_press); end
        nAsserts++;
        if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset.busy: got %b expected 0", busy); end
        nAsserts++;
        if (press_count !== 8'd0) begin nFails++; $display("[TB] FAIL reset.count: got %0d expected 0", press_count); end
        db      = 1'b0;
        reset_n = 1'b1;
        step(); step();
        nAsserts++;
        if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset.idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_short();
        logic busy5, busy21;
        busy5 = 1'b0; busy21 = 1'b1;
        do_reset();
        clear_obs();
        db = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            observe(e);
            if (e == 5)  busy5  = busy;
            if (e == 21) busy21 = busy;
            if (e == 8)  db = 1'b0;
        end
        nAsserts++;
        if (firstS !== 20) begin nFails++; $display("[TB] FAIL short.edge: got %0d expected 20", firstS); end
        nAsserts++;
        if (cntS !== 1) begin nFails++; $display("[TB] FAIL short.pulses: got %0d expected 1", cntS); end
        nAsserts++;
        if (cntL + cntD !== 0) begin nFails++; $display("[TB] FAIL short.other: got %0d expected 0", cntL + cntD); end
        nAsserts++;
        if (press_count !== 8'd1) begin nFails++; $display("[TB] FAIL short.count: got %0d expected 1", press_count); end
        nAsserts++;
        if (busy5 !== 1'b1) begin nFails++; $display("[TB] FAIL short.busy_during: got %b expected 1", busy5); end
        nAsserts++;
        if (busy21 !== 1'b0) begin nFails++; $display("[TB] FAIL short.busy_after: got %b expected 0", busy21); end
    endtask

    task automatic test_long();
        logic busy30, busy45;
        busy30 = 1'b0; busy45 = 1'b1;
        do_reset();
        clear_obs();
        db = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            step();
            observe(e);
            if (e == 30) busy30 = busy;
            if (e == 45) busy45 = busy;
            if (e == 40) db = 1'b0;
        end
        nAsserts++;
        if (firstL !== 20) begin nFails++; $display("[TB] FAIL long.edge: got %0d expected 20", firstL); end
        nAsserts++;
        if (cntL !== 1) begin nFails++; $display("[TB] FAIL long.pulses: got %0d expected 1", cntL); end
        nAsserts++;
        if (cntS + cntD !== 0) begin nFails++; $display("[TB] FAIL long.release_pulse: got %0d expected 0", cntS + cntD); end
        nAsserts++;
        if (press_count !== 8'd1) begin nFails++; $display("[TB] FAIL long.count: got %0d expected 1", press_count); end
        nAsserts++;
        if (busy30 !== 1'b1) begin nFails++; $display("[TB] FAIL long.busy_hold: got %b expected 1", busy30); end
        nAsserts++;
        if (busy45 !== 1'b0) begin nFails++; $display("[TB] FAIL long.busy_after: got %b expected 0", busy45); end
    endtask

    task automatic test_double();
        logic busy8, busy18;
        busy8 = 1'b0; busy18 = 1'b1;
        do_reset();
        clear_obs();
        db = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            observe(e);
            if (e == 8)  busy8  = busy;
            if (e == 18) busy18 = busy;
            if (e == 6)  db = 1'b0;
            if (e == 10) db = 1'b1;
            if (e == 16) db = 1'b0;
        end
        nAsserts++;
        if (firstD !== 17) begin nFails++; $display("[TB] FAIL double.edge: got %0d expected 17", firstD); end
        nAsserts++;
        if (cntD !== 1) begin nFails++; $display("[TB] FAIL double.pulses: got %0d expected 1", cntD); end
        nAsserts++;
        if (cntS !== 0) begin nFails++; $display("[TB] FAIL double.short: got %0d expected 0", cntS); end
        nAsserts++;
        if (press_count !== 8'd1) begin nFails++; $display("[TB] FAIL double.count: got %0d expected 1", press_count); end
        nAsserts++;
        if (busy8 !== 1'b1) begin nFails++; $display("[TB] FAIL double.busy_wait: got %b expected 1", busy8); end
        nAsserts++;
        if (busy18 !== 1'b0) begin nFails++; $display("[TB] FAIL double.busy_after: got %b expected 0", busy18); end
    endtask

    // Second rise lands on edge 12, the third tick seen in WAIT2.
    task automatic test_edge_vs_tick();
        logic busy13;
        busy13 = 1'b0;
        do_reset();
        clear_obs();
        db = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            observe(e);
            if (e == 13) busy13 = busy;
            if (e == 2)  db = 1'b0;
            if (e == 11) db = 1'b1;
            if (e == 14) db = 1'b0;
        end
        nAsserts++;
        if (cntS !== 0) begin nFails++; $display("[TB] FAIL edgetick.short: got %0d expected 0", cntS); end
        nAsserts++;
        if (firstD !== 15) begin nFails++; $display("[TB] FAIL edgetick.double_edge: got %0d expected 15", firstD); end
        nAsserts++;
        if (busy13 !== 1'b1) begin nFails++; $display("[TB] FAIL edgetick.busy: got %b expected 1", busy13); end
        nAsserts++;
        if (press_count !== 8'd1) begin nFails++; $display("[TB] FAIL edgetick.count: got %0d expected 1", press_count); end
    endtask

    // Runs with press_count left at 1 by the previous scenario.
    task automatic test_reset_midpress();
        db = 1'b1;
        step(); step(); step();
        nAsserts++;
        if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL midreset.busy_before: got %b expected 1", busy); end
        reset_n = 1'b0;
        step();
        nAsserts++;
        if ({short_press, long_press, double_press, busy} !== 4'b0000) begin
            nFails++;
            $display("[TB] FAIL midreset.outputs: got %b expected 0000", {short_press, long_press, double_press, busy});
        end
        nAsserts++;
        if (press_count !== 8'd0) begin nFails++; $display("[TB] FAIL midreset.count: got %0d expected 0", press_count); end
        step();
        reset_n = 1'b1;
        clear_obs();
        for (int e = 1; e <= 30; e++) begin
            step();
            observe(e);
            if (e == 4) db = 1'b0;
        end
        nAsserts++;
        if (firstS !== 16) begin nFails++; $display("[TB] FAIL midreset.short_edge: got %0d expected 16", firstS); end
        nAsserts++;
        if (cntS + cntL + cntD !== 1) begin nFails++; $display("[TB] FAIL midreset.pulses: got %0d expected 1", cntS + cntL + cntD); end
        nAsserts++;
        if (press_count !== 8'd1) begin nFails++; $display("[TB] FAIL midreset.count_after: got %0d expected 1", press_count); end
    endtask

    task automatic test_wrap();
        int pulses, others;
        logic [7:0] count255;
        pulses = 0; others = 0; count255 = 8'd0;
        do_reset();
        for (int p = 0; p < 256; p++) begin
            db = 1'b1;
            step(); step();
            db = 1'b0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (short_press) pulses++;
                if (long_press || double_press) others++;
            end
            if (p == 254) count255 = press_count;
        end
        nAsserts++;
        if (count255 !== 8'd255) begin nFails++; $display("[TB] FAIL wrap.count255: got %0d expected 255", count255); end
        nAsserts++;
        if (press_count !== 8'd0) begin nFails++; $display("[TB] FAIL wrap.count: got %0d expected 0", press_count); end
        nAsserts++;
        if (pulses !== 256) begin nFails++; $display("[TB] FAIL wrap.pulses: got %0d expected 256", pulses); end
        nAsserts++;
        if (others !== 0) begin nFails++; $display("[TB] FAIL wrap.other: got %0d expected 0", others); end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_edge_vs_tick();
        test_reset_midpress();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter TICK_BITS, default 19, width of the free-running tick prescaler (2^19 cycles ≈ 10 ms at 50 MHz).
REQ-002 Parameter LONG_TICKS, default 50, ticks a first press must be held to be classed long.
REQ-003 Parameter DBL_TICKS, default 25, ticks allowed between first release and second press for a double press.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  reset: asynchronous, active-low.
REQ-006 Port db  input  1  debounced, clk-synchronous button level from the debouncer stage; 1 = pressed.
REQ-007 Port short_press  output  1  one-cycle pulse: single short press completed.
REQ-008 Port long_press  output  1  one-cycle pulse: press held LONG_TICKS.
REQ-009 Port double_press  output  1  one-cycle pulse: two presses completed within the DBL_TICKS window.
REQ-010 Port busy  output  1  high whenever FSM is not IDLE.
REQ-011 Port press_count  output  8  count of classified events of any type.

Function
REQ-012 Prescaler SHALL be a free-running TICK_BITS counter; tick is high for one cycle when the counter equals all-ones, then the counter wraps to 0.
REQ-013 db SHALL be registered once (db_q); rise = db & ~db_q, fall = ~db & db_q.
REQ-014 Tick timer tcnt (7 bits) SHALL clear on every state entry, increment on each tick, and saturate at 127.
REQ-015 FSM states SHALL be IDLE, PRESS1, HOLD, WAIT2, PRESS2.
REQ-016 IDLE: rise -> PRESS1; otherwise stay.
REQ-017 PRESS1: fall -> WAIT2; else tick with tcnt == LONG_TICKS-1 -> HOLD and pulse long_press.
REQ-018 HOLD: fall -> IDLE with no pulse; release after a long press is silent.
REQ-019 WAIT2: rise -> PRESS2; else tick with tcnt == DBL_TICKS-1 -> IDLE and pulse short_press.
REQ-020 PRESS2: fall -> IDLE and pulse double_press, regardless of hold duration.
REQ-021 If an edge and a timeout tick occur in the same cycle, the edge SHALL win.
REQ-022 Output pulses SHALL be registered: high exactly one cycle, the cycle after the deciding edge or tick; at most one of the three is high in any cycle.
REQ-023 press_count SHALL increment in the same cycle any output pulse is high and wrap from 255 to 0.
REQ-024 busy SHALL be a registered decode of state != IDLE.
REQ-025 Unreachable state encodings SHALL return to IDLE on the next clock without a pulse.

Reset
REQ-026 While reset_n is low: state = IDLE, prescaler = 0, tcnt = 0, db_q = 0; short_press, long_press, double_press, busy = 0; press_count = 0.
REQ-027 Reset asserted mid-press SHALL drop the in-progress classification with no pulse; after release, a db already high SHALL be seen as a rise.

Structure
REQ-028 Shared package press_pkg SHALL hold the state enumeration/encoding constants and the default values of TICK_BITS, LONG_TICKS and DBL_TICKS.
REQ-029 The prescaler SHALL be a separate sub-module tick_gen (parameter TICK_BITS; ports clk, reset_n, tick).
REQ-030 Total RTL SHALL be 120-400 lines; no other sub-modules.

Verification (TICK_BITS=2 so tick every 4 cycles, LONG_TICKS=5, DBL_TICKS=3)
REQ-031 Short: db high 8 cycles, then low -> short_press single pulse after 3 further ticks; press_count 0 -> 1; busy low the next cycle.
REQ-032 Long: db held high 40 cycles -> long_press pulse on the 5th tick after rise; no pulse on release; press_count = 1.
REQ-033 Double: db high 6, low 4, high 6, low -> double_press on the cycle after the second fall; short_press never asserted.
REQ-034 Edge vs tick: second rise coincident with the 3rd WAIT2 tick -> enters PRESS2, no short_press.
REQ-035 Reset mid-PRESS1 (reset_n low 2 cycles, db stays high) -> all outputs 0; after reset, a new classification starts from the rise.
REQ-036 Wrap: 256 short presses -> press_count reads 0 and short_press pulsed 256 times.
